game_sequencer: RTL
===================

Name: game_sequencer

Overview:
- Top-level game-flow controller that drives the `start_game` and `animation` inputs of the map draw stages (ladders, platforms, sprites).
- Also drives the freeze/status signals used by the player and barrel logic.
- Frame-based FSM: intro, play, death, win and game-over phases are counted in video frames, using rising edges of the vertical blanking signal from the VGA timing chain.

Parameters:
- INTRO_FRAMES, 120, frames spent in INTRO with `animation` high (1..255)
- DEATH_FRAMES, 90, frames frozen after the player dies (1..255)
- END_FRAMES, 180, frames held in WIN or OVER before leaving (1..255)
- LIVES, 3, lives loaded at game start (1..3)

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- vblnk  in  1  vertical blank from the VGA timing chain
- start_btn  in  1  raw start button, asynchronous to clk
- player_dead  in  1  pulse or level from collision logic
- level_done  in  1  pulse or level when the player reaches the goal
- start_game  out  1  map/game drawing enabled
- animation  out  1  intro animation active (draw stages hide ladders)
- freeze  out  1  player and barrel motion halted
- game_over  out  1  high in OVER
- win  out  1  high in WIN
- lives  out  2  remaining lives
- state  out  3  current state code, for debug/HUD
- pause_btn  in  1  present only with PAUSE_EN; raw, asynchronous

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, frame counter=0, and all outputs 0, including `lives`=0.
- Synchronizers: `start_btn` (and `pause_btn` with PAUSE_EN) pass through a 2-flop synchronizer, then a rising-edge detector. The result is a 1-cycle press pulse, 3 cycles after the input edge.
- frame_tick: `vblnk` & ~`vblnk_d`, where `vblnk_d` is `vblnk` registered. frame_tick is 1 cycle per frame.
- Frame counter:
  - 8 bits wide.
  - Cleared on every state transition.
  - Increments on frame_tick.
  - A phase with parameter N ends on the frame_tick where count==N-1, so the phase lasts exactly N ticks.
- States and codes:
  - IDLE=0, INTRO=1, PLAY=2, DEATH=3, WIN=4, OVER=5, PAUSE=6.
- Transitions:
  - IDLE: start press -> INTRO, with `lives` loaded to LIVES.
  - INTRO: N=INTRO_FRAMES elapsed -> PLAY.
  - PLAY: `player_dead` -> DEATH; else `level_done` -> WIN. If both are asserted in the same cycle, DEATH wins.
  - DEATH, after DEATH_FRAMES:
    - `lives`>1 -> `lives`-1, then INTRO.
    - `lives`==1 -> `lives`=0, then OVER.
  - WIN: after END_FRAMES -> INTRO; `lives` unchanged.
  - OVER: after END_FRAMES -> IDLE; `lives` stays 0.
- Inputs ignored outside their states:
  - Start presses outside IDLE are ignored.
  - `player_dead`/`level_done` outside PLAY are ignored.
- Outputs are registered, computed from next-state, so they change on the same clock edge as `state`:
  - `start_game`=1 in every state except IDLE.
  - `animation`=1 only in INTRO.
  - `freeze`=1 in INTRO, DEATH, WIN, OVER and PAUSE.
  - `game_over`=1 only in OVER.
  - `win`=1 only in WIN.
- Arithmetic: `lives` never underflows; decrement only happens when `lives`>1. The counter saturates at 255 and does not wrap.
- Reset mid-operation returns to IDLE immediately; no phase completes.

Optional Feature:
- Macro: GAME_SEQUENCER_PAUSE_EN.
- Defined:
  - Adds the `pause_btn` port.
  - In PLAY, a pause press -> PAUSE: `freeze`=1, `start_game`=1.
  - In PAUSE, a pause press -> PLAY.
  - The frame counter holds during PAUSE.
  - `player_dead`/`level_done` are ignored in PAUSE.
  - If a pause press and `player_dead` occur in the same PLAY cycle, DEATH wins.
- Not defined: no `pause_btn` port, PAUSE state unreachable, state code 6 never appears.

Test Plan:
- Reset then idle: hold rst_n low and release; drive vblnk frames with no start press -> `state`=0, `lives`=0 and all flags 0 for 10 frames.
- Start press in IDLE -> INTRO; `lives`=3, `start_game`=1, `animation`=1, `freeze`=1. After exactly 120 vblnk rising edges -> PLAY with `animation`=0, `freeze`=0.
- Three deaths in PLAY -> `lives` steps 3->2->1. Each death holds `freeze` for 90 frames, then replays INTRO. The third death -> OVER, `game_over`=1 for 180 frames, then IDLE.
- In PLAY, pulse `player_dead` and `level_done` in the same cycle -> DEATH, `win` stays 0. In a separate PLAY phase, `level_done` alone -> WIN for 180 frames, then INTRO with `lives` unchanged.
- Assert rst_n low mid-INTRO at frame 60 -> state goes to IDLE asynchronously (before the next clk edge) and all outputs 0. A start press during PLAY causes no state change.
- With GAME_SEQUENCER_PAUSE_EN, pause in PLAY -> `state`=6, `freeze`=1. Hold paused 50 frames, unpause -> PLAY. A `player_dead` pulse during PAUSE is ignored.

Source files
------------

// File: rtl/game_sequencer.sv
// Frame-counted game-flow FSM (IDLE/INTRO/PLAY/DEATH/WIN/OVER) driving draw-stage and freeze controls.
// Optional PAUSE state and pause_btn port with `define GAME_SEQUENCER_PAUSE_EN.
module game_sequencer #(
  parameter int INTRO_FRAMES = 120,
  parameter int DEATH_FRAMES = 90,
  parameter int END_FRAMES   = 180,
  parameter int LIVES        = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vblnk,
  input  logic       start_btn,
`ifdef GAME_SEQUENCER_PAUSE_EN
  input  logic       pause_btn,
`endif
  input  logic       player_dead,
  input  logic       level_done,
  output logic       start_game,
  output logic       animation,
  output logic       freeze,
  output logic       game_over,
  output logic       win,
  output logic [1:0] lives,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INTRO = 3'd1,
    S_PLAY  = 3'd2,
    S_DEATH = 3'd3,
    S_WIN   = 3'd4,
    S_OVER  = 3'd5,
    S_PAUSE = 3'd6
  } state_t;

  localparam logic [7:0] INTRO_LAST = 8'(INTRO_FRAMES - 1);
  localparam logic [7:0] DEATH_LAST = 8'(DEATH_FRAMES - 1);
  localparam logic [7:0] END_LAST   = 8'(END_FRAMES - 1);
  localparam logic [1:0] LIVES_INIT = 2'(LIVES);

  state_t      cur, nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic [1:0]  lives_nxt;
  logic [1:0]  start_sync;
  logic        start_d;
  logic        vblnk_d;
  logic        start_press;
  logic        pause_press;
  logic        frame_tick;

  assign start_press = start_sync[1] & ~start_d;
  assign frame_tick  = vblnk & ~vblnk_d;
  assign state       = cur;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_sync <= 2'b00;
      start_d    <= 1'b0;
      vblnk_d    <= 1'b0;
    end else begin
      start_sync <= {start_sync[0], start_btn};
      start_d    <= start_sync[1];
      vblnk_d    <= vblnk;
    end
  end

`ifdef GAME_SEQUENCER_PAUSE_EN
  logic [1:0] pause_sync;
  logic       pause_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pause_sync <= 2'b00;
      pause_d    <= 1'b0;
    end else begin
      pause_sync <= {pause_sync[0], pause_btn};
      pause_d    <= pause_sync[1];
    end
  end

  assign pause_press = pause_sync[1] & ~pause_d;
`else
  assign pause_press = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur        <= S_IDLE;
      cnt        <= 8'd0;
      lives      <= 2'd0;
      start_game <= 1'b0;
      animation  <= 1'b0;
      freeze     <= 1'b0;
      game_over  <= 1'b0;
      win        <= 1'b0;
    end else begin
      cur        <= nxt;
      cnt        <= cnt_nxt;
      lives      <= lives_nxt;
      start_game <= (nxt != S_IDLE);
      animation  <= (nxt == S_INTRO);
      freeze     <= (nxt == S_INTRO) || (nxt == S_DEATH) || (nxt == S_WIN) ||
                    (nxt == S_OVER)  || (nxt == S_PAUSE);
      game_over  <= (nxt == S_OVER);
      win        <= (nxt == S_WIN);
    end
  end

  always_comb begin
    nxt       = cur;
    lives_nxt = lives;
    cnt_nxt   = cnt;
    case (cur)
      S_IDLE: begin
        if (start_press) begin
          nxt       = S_INTRO;
          lives_nxt = LIVES_INIT;
        end
      end
      S_INTRO: begin
        if (frame_tick && cnt == INTRO_LAST) nxt = S_PLAY;
      end
      S_PLAY: begin
        // Death takes priority over both the goal and a simultaneous pause.
        if (player_dead)      nxt = S_DEATH;
        else if (level_done)  nxt = S_WIN;
        else if (pause_press) nxt = S_PAUSE;
      end
      S_DEATH: begin
        if (frame_tick && cnt == DEATH_LAST) begin
          if (lives > 2'd1) begin
            lives_nxt = lives - 2'd1;
            nxt       = S_INTRO;
          end else begin
            lives_nxt = 2'd0;
            nxt       = S_OVER;
          end
        end
      end
      S_WIN: begin
        if (frame_tick && cnt == END_LAST) nxt = S_INTRO;
      end
      S_OVER: begin
        if (frame_tick && cnt == END_LAST) nxt = S_IDLE;
      end
      S_PAUSE: begin
        if (pause_press) nxt = S_PLAY;
      end
      default: nxt = S_IDLE;
    endcase

    // Counter restarts with each phase, freezes while paused, saturates at 255.
    if (nxt != cur)
      cnt_nxt = 8'd0;
    else if (cur != S_PAUSE && frame_tick && cnt != 8'hFF)
      cnt_nxt = cnt + 8'd1;
  end

endmodule
